// File: rtl/operand_stream_if.sv
// Operand stream handshake: data word with strobe from the source and ack from the sink.
interface operand_stream_if #(
  parameter int WIDTH = 64
) ();
  logic [WIDTH-1:0] dat;
  logic             stb;
  logic             ack;

  modport master (output dat, output stb, input ack);
  modport slave  (input dat, input stb, output ack);
endinterface

// File: rtl/operand_stream_src.sv
// Operand source for the FP multiplier: a RAM of packed {a,b} operand pairs is loaded
// through a write port, then the first n words are streamed out in address order,
// one stb/ack handshake per word.
module operand_stream_src #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   num_of_dat,
  operand_stream_if.master  out,
  output logic              busy,
  output logic [ADDR_W:0]   sent_cnt,
  output logic              done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] DONE_S = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]       state;
  logic [ADDR_W:0]  n_q;
  logic [ADDR_W:0]  idx;
  logic [ADDR_W:0]  idx_nxt;
  logic [ADDR_W:0]  n_clamp;
  logic [WIDTH-1:0] mem [DEPTH];

  // Requests beyond the RAM size are clamped so the read index never wraps.
  assign n_clamp = (num_of_dat > DEPTH_L) ? DEPTH_L : num_of_dat;
  assign idx_nxt = idx + 1'b1;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE_S);

  // Operand RAM write port; not reset so contents survive a stream abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stream FSM; the FETCH read sees the pre-write word on a same-edge write (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_q      <= '0;
      idx      <= '0;
      sent_cnt <= '0;
      out.dat  <= '0;
      out.stb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q      <= n_clamp;
            idx      <= '0;
            sent_cnt <= '0;
            state    <= (n_clamp == '0) ? DONE_S : FETCH;
          end
        end
        FETCH: begin
          out.dat <= mem[idx[ADDR_W-1:0]];
          out.stb <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (out.ack) begin
            out.stb  <= 1'b0;
            sent_cnt <= sent_cnt + 1'b1;
            idx      <= idx_nxt;
            state    <= (idx_nxt == n_q) ? DONE_S : FETCH;
          end
        end
        DONE_S: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stream_src.sv
// Bench for operand_stream_src: a snapshot-of-RAM stream model with a per-cycle compare
// process, plus directed scenarios with literal expectations.
module tb_operand_stream_src;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        start = 1'b0;
  logic [6:0]  num_of_dat = '0;
  logic        busy;
  logic [6:0]  sent_cnt;
  logic        done;

  operand_stream_if #(.WIDTH(64)) sif ();

  operand_stream_src #(.WIDTH(64), .DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_of_dat(num_of_dat), .out(sif), .busy(busy),
    .sent_cnt(sent_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miscmp = 0;

  // model state
  logic [63:0] model_mem [64];
  logic [63:0] q [$];
  bit          active_m = 0;
  bit          done_m = 0;
  int          cnt_m = 0;
  bit          last_xfer = 0;
  bit          hold = 0;
  logic [63:0] prev_dat = '0;
  logic [63:0] last_dat = '0;
  int          xfer_cnt = 0;
  int          busy_cycles = 0;
  int          done_cycles = 0;
  bit          chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each edge: consume a word on every handshake.
  always @(posedge clk) begin
    if (done_m) begin
      done_m   = 0;
      active_m = 0;
    end
    hold     = sif.stb && !sif.ack;
    prev_dat = sif.dat;
    if (sif.stb && sif.ack) begin
      last_xfer = 1;
      last_dat  = sif.dat;
      xfer_cnt++;
      cnt_m++;
      if (q.size() > 0) void'(q.pop_front());
      if (q.size() == 0) done_m = 1;
    end else begin
      last_xfer = 0;
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(active_m));
      chk("done", 64'(done), 64'(done_m));
      chk("sent_cnt", 64'(sent_cnt), 64'(cnt_m));
      if (!active_m || last_xfer) chk("stb_low", 64'(sif.stb), 64'd0);
      if (hold) begin
        chk("stb_hold", 64'(sif.stb), 64'd1);
        chk("dat_hold", sif.dat, prev_dat);
      end
      if (sif.stb) begin
        if (q.size() == 0) chk("dat_unexpected", 64'd1, 64'd0);
        else chk("dat", sif.dat, q[0]);
      end
      if (busy) busy_cycles++;
      if (done) done_cycles++;
    end
  end

  task automatic wr(input int a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    model_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called at a negedge while idle; returns just after the sampling edge.
  task automatic start_stream(input int n);
    int ne;
    start = 1'b1; num_of_dat = 7'(n);
    @(posedge clk); #1;
    start = 1'b0;
    ne = (n > 64) ? 64 : n;
    q.delete();
    for (int i = 0; i < ne; i++) q.push_back(model_mem[i]);
    cnt_m = 0;
    active_m = 1;
    done_m = (ne == 0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (!active_m) break;
    end
    if (active_m) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  int x0, b0, d0;

  initial begin
    sif.ack = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_stb", 64'(sif.stb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", 64'(sent_cnt), 64'd0);
    chk("rst_dat", sif.dat, 64'd0);
    rst_n = 1'b1;
    chk_en = 1;
    @(negedge clk);

    // Load operand pairs
    wr(0, 64'h3F800000_40000000);
    wr(1, 64'h40400000_40800000);
    wr(2, 64'hC0000000_3F000000);
    wr(3, 64'h00000000_7F800000);

    // Basic stream, ack tied high
    sif.ack = 1'b1;
    x0 = xfer_cnt; b0 = busy_cycles; d0 = done_cycles;
    start_stream(4);
    @(negedge clk);
    chk("lat_fetch_stb", 64'(sif.stb), 64'd0);
    @(negedge clk);
    chk("lat_send_stb", 64'(sif.stb), 64'd1);
    chk("first_word", sif.dat, 64'h3F800000_40000000);
    wait_idle(40);
    chk("basic_xfers", 64'(xfer_cnt - x0), 64'd4);
    chk("basic_sent_cnt", 64'(sent_cnt), 64'd4);
    chk("basic_last", last_dat, 64'h00000000_7F800000);
    chk("basic_busy_cycles", 64'(busy_cycles - b0), 64'd9);
    chk("basic_done_cycles", 64'(done_cycles - d0), 64'd1);
    chk("basic_hold_dat", sif.dat, 64'h00000000_7F800000);

    // Backpressure: ack low for 5 cycles in SEND
    sif.ack = 1'b0;
    x0 = xfer_cnt;
    start_stream(3);
    @(negedge clk); @(negedge clk);
    repeat (5) @(negedge clk);
    chk("bp_stb_held", 64'(sif.stb), 64'd1);
    chk("bp_dat_held", sif.dat, 64'h3F800000_40000000);
    chk("bp_no_xfer", 64'(xfer_cnt - x0), 64'd0);
    sif.ack = 1'b1;
    wait_idle(40);
    chk("bp_xfers", 64'(xfer_cnt - x0), 64'd3);
    chk("bp_last", last_dat, 64'hC0000000_3F000000);

    // n = 0: no strobe, done one cycle after the sampling edge
    x0 = xfer_cnt; b0 = busy_cycles;
    start_stream(0);
    @(negedge clk);
    chk("n0_done", 64'(done), 64'd1);
    chk("n0_stb", 64'(sif.stb), 64'd0);
    @(negedge clk);
    chk("n0_done_clr", 64'(done), 64'd0);
    chk("n0_busy", 64'(busy), 64'd0);
    chk("n0_xfers", 64'(xfer_cnt - x0), 64'd0);
    chk("n0_busy_cycles", 64'(busy_cycles - b0), 64'd1);

    // n = 100 clamps to the full RAM
    for (int i = 4; i < 64; i++) wr(i, {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)});
    x0 = xfer_cnt; b0 = busy_cycles;
    start_stream(100);
    wait_idle(400);
    chk("clamp_xfers", 64'(xfer_cnt - x0), 64'd64);
    chk("clamp_sent_cnt", 64'(sent_cnt), 64'd64);
    chk("clamp_last", last_dat, 64'h1000003F_2000003F);
    chk("clamp_busy_cycles", 64'(busy_cycles - b0), 64'd129);

    // start while busy is ignored
    x0 = xfer_cnt;
    start_stream(3);
    @(negedge clk); @(negedge clk);
    start = 1'b1; num_of_dat = 7'd1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_sent_cnt", 64'(sent_cnt), 64'd1);
    wait_idle(40);
    chk("ign_xfers", 64'(xfer_cnt - x0), 64'd3);
    chk("ign_sent_final", 64'(sent_cnt), 64'd3);

    // Write RAM[1] during its FETCH cycle: old word goes out
    sif.ack = 1'b0;
    start_stream(2);
    @(negedge clk);
    @(negedge clk);
    sif.ack = 1'b1;
    @(negedge clk);
    sif.ack = 1'b0;
    wr(1, 64'h12345678_9ABCDEF0);
    chk("rf_old_word", sif.dat, 64'h40400000_40800000);
    sif.ack = 1'b1;
    wait_idle(40);
    chk("rf_last_old", last_dat, 64'h40400000_40800000);
    start_stream(2);
    wait_idle(40);
    chk("rf_last_new", last_dat, 64'h12345678_9ABCDEF0);

    // Async reset mid-SEND after one transfer
    sif.ack = 1'b0;
    start_stream(4);
    @(negedge clk); @(negedge clk);
    sif.ack = 1'b1;
    @(negedge clk);
    sif.ack = 1'b0;
    @(negedge clk);
    chk("pre_rst_stb", 64'(sif.stb), 64'd1);
    chk("pre_rst_cnt", 64'(sent_cnt), 64'd1);
    #2 rst_n = 1'b0;
    q.delete(); active_m = 0; done_m = 0; cnt_m = 0; hold = 0; last_xfer = 0;
    #1;
    chk("async_rst_stb", 64'(sif.stb), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_cnt", 64'(sent_cnt), 64'd0);
    chk("async_rst_dat", sif.dat, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // RAM survives reset
    sif.ack = 1'b1;
    start_stream(2);
    wait_idle(40);
    chk("post_rst_last", last_dat, 64'h12345678_9ABCDEF0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    miscmp++;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $fatal(1);
  end

endmodule
